// File: rtl/fu_share_ctrl.sv
// fu_share_ctrl: round-robin front end for one shared pipelined arithmetic unit.
// Four requesters compete for a single issue slot per cycle. The winner's
// opcode and operands are captured into stage 0. The operation is evaluated
// from stage 0 and then carried through LATENCY result stages. The result
// leaves the last stage tagged with the requester index, so results return
// in accept order at one per cycle.
module fu_share_ctrl #(
  parameter int DATAWIDTH = 8,
  parameter int LATENCY   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             req,
  input  logic [11:0]            op,
  input  logic [4*DATAWIDTH-1:0] a_in,
  input  logic [4*DATAWIDTH-1:0] b_in,
  input  logic                   hold,
  output logic [3:0]             gnt,
  output logic                   busy,
  output logic                   res_valid,
  output logic [1:0]             res_tag,
  output logic [DATAWIDTH-1:0]   res,
  output logic [2:0]             cmp
);

  localparam int SHW = $clog2(DATAWIDTH);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_DIV  = 3'b011,
    OP_MOD  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_COMP = 3'b111
  } op_e;

  // Per-requester views of the flat input buses
  logic [2:0]           op_arr [4];
  logic [DATAWIDTH-1:0] a_arr  [4];
  logic [DATAWIDTH-1:0] b_arr  [4];

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_req
    assign op_arr[gi] = op[3*gi +: 3];
    assign a_arr[gi]  = a_in[DATAWIDTH*gi +: DATAWIDTH];
    assign b_arr[gi]  = b_in[DATAWIDTH*gi +: DATAWIDTH];
  end

  // Arbiter state
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_idx;
  logic [1:0] scan_idx;
  logic       gnt_any;

  // Stage 0: captured request. Stages 1..LATENCY: results.
  // v_q[0] is the stage-0 valid and v_q[s] is the valid of result stage s.
  logic [LATENCY:0]     v_q, v_d;
  logic [2:0]           s0_op_q, s0_op_d;
  logic [DATAWIDTH-1:0] s0_a_q, s0_a_d;
  logic [DATAWIDTH-1:0] s0_b_q, s0_b_d;
  logic [1:0]           s0_tag_q, s0_tag_d;

  logic [DATAWIDTH-1:0] res_q [1:LATENCY];
  logic [DATAWIDTH-1:0] res_d [1:LATENCY];
  logic [1:0]           tag_q [1:LATENCY];
  logic [1:0]           tag_d [1:LATENCY];
  logic [2:0]           cmp_q [1:LATENCY];
  logic [2:0]           cmp_d [1:LATENCY];

  logic [DATAWIDTH-1:0] alu_res;
  logic [2:0]           alu_cmp;
  logic [SHW-1:0]       shamt;

  // Round-robin grant: first asserted request at or after ptr, wrapping mod 4.
  // Reset and hold both suppress every grant. Opcodes and operands play no part.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    if (rst && !hold) begin
      for (int k = 0; k < 4; k++) begin
        scan_idx = ptr_q + 2'(k);
        if (!gnt_any && req[scan_idx]) begin
          gnt_any       = 1'b1;
          gnt[scan_idx] = 1'b1;
          gnt_idx       = scan_idx;
        end
      end
    end
    ptr_d = gnt_any ? gnt_idx + 2'd1 : ptr_q;
  end

  // Shared arithmetic unit, evaluated from the stage-0 registers
  always_comb begin
    alu_res = '0;
    shamt   = s0_b_q[SHW-1:0];
    case (op_e'(s0_op_q))
      OP_ADD:  alu_res = s0_a_q + s0_b_q;
      OP_SUB:  alu_res = s0_a_q - s0_b_q;
      OP_MUL:  alu_res = s0_a_q * s0_b_q;
      OP_DIV:  alu_res = (s0_b_q == '0) ? '1 : s0_a_q / s0_b_q;
      OP_MOD:  alu_res = (s0_b_q == '0) ? s0_a_q : s0_a_q % s0_b_q;
      OP_SHL:  alu_res = s0_a_q << shamt;
      OP_SHR:  alu_res = s0_a_q >> shamt;
      OP_COMP: alu_res = '0;
      default: alu_res = '0;
    endcase
    alu_cmp = {s0_a_q > s0_b_q, s0_a_q < s0_b_q, s0_a_q == s0_b_q};
  end

  // Next state of the issue stage and the result shift chain.
  // A stage loads its payload only when valid data arrives, so the last stage
  // (the visible outputs) keeps its value between results.
  always_comb begin
    v_d[0]   = gnt_any;
    s0_op_d  = s0_op_q;
    s0_a_d   = s0_a_q;
    s0_b_d   = s0_b_q;
    s0_tag_d = s0_tag_q;
    if (gnt_any) begin
      s0_op_d  = op_arr[gnt_idx];
      s0_a_d   = a_arr[gnt_idx];
      s0_b_d   = b_arr[gnt_idx];
      s0_tag_d = gnt_idx;
    end
    for (int s = 1; s <= LATENCY; s++) begin
      v_d[s]   = v_q[s-1];
      res_d[s] = res_q[s];
      tag_d[s] = tag_q[s];
      cmp_d[s] = cmp_q[s];
    end
    if (v_q[0]) begin
      res_d[1] = alu_res;
      tag_d[1] = s0_tag_q;
      cmp_d[1] = alu_cmp;
    end
    for (int s = 2; s <= LATENCY; s++) begin
      if (v_q[s-1]) begin
        res_d[s] = res_q[s-1];
        tag_d[s] = tag_q[s-1];
        cmp_d[s] = cmp_q[s-1];
      end
    end
  end

  // State registers; reset discards every in-flight operation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      v_q      <= '0;
      s0_op_q  <= '0;
      s0_a_q   <= '0;
      s0_b_q   <= '0;
      s0_tag_q <= '0;
      for (int s = 1; s <= LATENCY; s++) begin
        res_q[s] <= '0;
        tag_q[s] <= '0;
        cmp_q[s] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      v_q      <= v_d;
      s0_op_q  <= s0_op_d;
      s0_a_q   <= s0_a_d;
      s0_b_q   <= s0_b_d;
      s0_tag_q <= s0_tag_d;
      for (int s = 1; s <= LATENCY; s++) begin
        res_q[s] <= res_d[s];
        tag_q[s] <= tag_d[s];
        cmp_q[s] <= cmp_d[s];
      end
    end
  end

  assign busy      = |v_q;
  assign res_valid = v_q[LATENCY];
  assign res       = res_q[LATENCY];
  assign res_tag   = tag_q[LATENCY];
  assign cmp       = cmp_q[LATENCY];

endmodule

// File: tb/tb_fu_share_ctrl.sv
// Self-checking bench for fu_share_ctrl. A scoreboard predicts grants from a
// round-robin pointer and predicts results from plain arithmetic. Each accepted
// operation waits in a queue and becomes visible LATENCY cycles after it is accepted.
module tb_fu_share_ctrl;
  localparam int W    = 8;
  localparam int L    = 2;
  localparam int MASK = (1 << W) - 1;

  logic           clk   = 1'b0;
  logic           rst   = 1'b0;
  logic [3:0]     req   = '0;
  logic [11:0]    op    = '0;
  logic [4*W-1:0] a_in  = '0;
  logic [4*W-1:0] b_in  = '0;
  logic           hold  = 1'b0;
  logic [3:0]     gnt;
  logic           busy;
  logic           res_valid;
  logic [1:0]     res_tag;
  logic [W-1:0]   res;
  logic [2:0]     cmp;

  fu_share_ctrl #(.DATAWIDTH(W), .LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a_in(a_in), .b_in(b_in),
    .hold(hold), .gnt(gnt), .busy(busy), .res_valid(res_valid),
    .res_tag(res_tag), .res(res), .cmp(cmp)
  );

  always #5 clk = ~clk;

  typedef struct { int tag; int val; int flags; int age; } ent_t;
  typedef struct { int tag; int val; int flags; } out_t;
  typedef struct { int opc; int a; int b; int exp_val; int exp_flags; } vec_t;

  ent_t       mq[$];
  out_t       got[$];
  out_t       m_last;
  int         m_ptr;
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [3:0] obs_gnt;
  logic [3:0] last_eg;
  vec_t       t3[10];
  vec_t       t4[3];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic h,
                                           input logic rn, input int p);
    if (h || !rn) return 4'b0000;
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return 4'(1 << ((p + k) % 4));
    return 4'b0000;
  endfunction

  function automatic int model_val(input int o, input int a, input int b);
    case (o)
      0: return (a + b) & MASK;
      1: return (a - b) & MASK;
      2: return (a * b) & MASK;
      3: return (b == 0) ? MASK : a / b;
      4: return (b == 0) ? a : a % b;
      5: return (a << (b % W)) & MASK;
      6: return a >> (b % W);
      default: return 0;
    endcase
  endfunction

  function automatic int model_flags(input int a, input int b);
    if (a > b) return 4;
    if (a < b) return 2;
    return 1;
  endfunction

  task automatic set_op(input int i, input int o, input int a, input int b);
    op[3*i +: 3]   = 3'(o);
    a_in[W*i +: W] = W'(a);
    b_in[W*i +: W] = W'(b);
  endtask

  // One clock cycle: compare everything at the falling edge, then advance the model
  task automatic tick();
    logic [3:0] eg;
    bit         ev;
    ent_t       e;
    out_t       o;
    int         idx;
    int         oa;
    int         ob;
    @(negedge clk);
    eg      = model_gnt(req, hold, rst, m_ptr);
    obs_gnt = gnt;
    last_eg = eg;
    check("gnt", int'(gnt), int'(eg));
    ev = (mq.size() > 0) && (mq[0].age == L);
    if (ev) begin
      m_last.tag   = mq[0].tag;
      m_last.val   = mq[0].val;
      m_last.flags = mq[0].flags;
    end
    check("res_valid", int'(res_valid), int'(ev));
    check("res", int'(res), m_last.val);
    check("res_tag", int'(res_tag), m_last.tag);
    check("cmp", int'(cmp), m_last.flags);
    check("busy", int'(busy), int'(mq.size() > 0));
    if (res_valid) begin
      o.tag = int'(res_tag); o.val = int'(res); o.flags = int'(cmp);
      got.push_back(o);
      $display("result tag=%0d res=0x%02h cmp=%03b", res_tag, res, cmp);
    end
    @(posedge clk);
    if (rst) begin
      if (ev) void'(mq.pop_front());
      foreach (mq[i]) mq[i].age++;
      if (eg != 4'b0000) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (eg[k]) idx = k;
        oa = int'(a_in[W*idx +: W]);
        ob = int'(b_in[W*idx +: W]);
        e.tag   = idx;
        e.val   = model_val(int'(op[3*idx +: 3]), oa, ob);
        e.flags = model_flags(oa, ob);
        e.age   = 0;
        mq.push_back(e);
        m_ptr = (idx + 1) % 4;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst  = 1'b0;
    req  = '0; hold = 1'b0; op = '0; a_in = '0; b_in = '0;
    mq.delete();
    m_ptr  = 0;
    m_last = '{0, 0, 0};
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  function automatic out_t got_at(input int i);
    out_t none;
    none = '{-1, -1, -1};
    if (i < got.size()) return got[i];
    return none;
  endfunction

  initial begin
    logic [3:0] exp2[5];
    t3[0] = '{3, 6, 3, 2, 0};    t3[1] = '{4, 7, 3, 1, 0};
    t3[2] = '{2, 4, 2, 8, 0};    t3[3] = '{2, 16, 16, 0, 0};
    t3[4] = '{1, 5, 4, 1, 0};    t3[5] = '{1, 0, 1, 255, 0};
    t3[6] = '{5, 1, 1, 2, 0};    t3[7] = '{6, 8, 2, 2, 0};
    t3[8] = '{3, 9, 0, 255, 0};  t3[9] = '{4, 9, 0, 9, 0};
    t4[0] = '{7, 2, 3, 0, 2};    t4[1] = '{7, 3, 3, 0, 1};
    t4[2] = '{7, 4, 3, 0, 4};
    exp2[0] = 4'b0001; exp2[1] = 4'b0010; exp2[2] = 4'b0100;
    exp2[3] = 4'b1000; exp2[4] = 4'b0001;

    // Reset state, then a single ADD from requester 2
    do_reset(2);
    got.delete();
    set_op(2, 0, 1, 2);
    req = 4'b0100;
    tick();
    check("t1_gnt", int'(obs_gnt), 4);
    req = 4'b0000;
    tick();
    check("t1_busy", int'(busy), 1);
    repeat (L + 1) tick();
    check("t1_res", got_at(0).val, 3);
    check("t1_tag", got_at(0).tag, 2);
    check("t1_cmp", got_at(0).flags, 2);

    // All four requesting continuously from reset
    do_reset(1);
    got.delete();
    for (int i = 0; i < 4; i++) set_op(i, 0, i, 0);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("t2_gnt_seq", int'(obs_gnt), int'(exp2[c]));
    end
    req = 4'b0000;
    repeat (L + 2) tick();
    for (int i = 0; i < 5; i++) check("t2_tag_seq", got_at(i).tag, i % 4);

    // Back-to-back ops from requester 1, table driven
    got.delete();
    for (int i = 0; i < 10; i++) begin
      set_op(1, t3[i].opc, t3[i].a, t3[i].b);
      req = 4'b0010;
      tick();
    end
    req = 4'b0000;
    repeat (L + 2) tick();
    check("t3_count", got.size(), 10);
    for (int i = 0; i < 10; i++) check("t3_res", got_at(i).val, t3[i].exp_val);

    // COMP flags from requester 3
    got.delete();
    for (int i = 0; i < 3; i++) begin
      set_op(3, t4[i].opc, t4[i].a, t4[i].b);
      req = 4'b1000;
      tick();
    end
    req = 4'b0000;
    repeat (L + 2) tick();
    for (int i = 0; i < 3; i++) begin
      check("t4_res", got_at(i).val, 0);
      check("t4_cmp", got_at(i).flags, t4[i].exp_flags);
    end

    // Hold with two ops in flight; grants resume from the pointer
    got.delete();
    set_op(0, 0, 10, 20);
    set_op(1, 1, 30, 5);
    req = 4'b0011;
    tick();
    tick();
    hold = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_hold_gnt", int'(obs_gnt), 0);
    end
    check("t5_drained", got.size(), 2);
    hold = 1'b0;
    tick();
    check("t5_resume_gnt", int'(obs_gnt), 1);
    req = 4'b0000;
    repeat (L + 2) tick();

    // Reset one cycle after an accept discards the op
    got.delete();
    set_op(2, 0, 7, 7);
    req = 4'b0100;
    tick();
    do_reset(L + 2);
    check("t6_no_result", got.size(), 0);
    check("t6_res", int'(res), 0);
    check("t6_busy", int'(busy), 0);
    set_op(0, 0, 1, 1);
    set_op(3, 0, 2, 2);
    req = 4'b1001;
    tick();
    check("t6_first_gnt", int'(obs_gnt), 1);
    req = req & ~last_eg;
    tick();
    req = 4'b0000;
    repeat (L + 2) tick();

    // Random traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 2) != 0) begin
          set_op(i, int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
                 ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, MASK)));
          req[i] = 1'b1;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      tick();
      req = req & ~last_eg;
    end
    req  = 4'b0000;
    hold = 1'b0;
    repeat (L + 3) tick();
    check("final_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fu_share_ctrl.md
Name: fu_share_ctrl

Overview:
- Arbitrated controller that shares one pipelined arithmetic unit among 4 requesters.
- Supported operations: ADD, SUB, MUL, DIV, MOD, SHL, SHR, COMP.
- Grants one requester per cycle (round-robin), captures its operands, sequences them through a LATENCY-deep result pipeline, and returns each result tagged with the requester index.
- Sits between datapath clients and the shared functional unit inside MAIN-level designs.

Parameters:
- DATAWIDTH, 8, operand/result width (>=2).
- LATENCY, 2, edges from accept to result register output (1..4).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  4  per-requester request; held until granted.
- op  input  12  3-bit opcode per requester; requester i uses op[3i+2:3i].
- a_in  input  4*DATAWIDTH  operand A per requester, slice i.
- b_in  input  4*DATAWIDTH  operand B per requester, slice i.
- hold  input  1  blocks new grants; pipeline keeps draining.
- gnt  output  4  one-hot grant, combinational, same cycle as accept.
- busy  output  1  any operation in flight.
- res_valid  output  1  one-cycle pulse, result valid.
- res_tag  output  2  requester index of current result.
- res  output  DATAWIDTH  result value.
- cmp  output  3  {gt,lt,eq} of the operands, unsigned, valid with res_valid for every op.

Behaviour:
- Reset (rst=0, async): ptr=0, all pipeline valids=0, res=0, res_tag=0, cmp=0, res_valid=0, busy=0, gnt forced 0. In-flight ops are discarded and never produce res_valid.
- Arbitration:
  - Round-robin pointer ptr (2 bits).
  - gnt selects the first asserted req scanning ptr, ptr+1, ... with wrap mod 4.
  - gnt=0 when hold=1 or req=0.
  - Accept means gnt[i]=1 at a rising edge. On accept, ptr <= (i+1) mod 4; otherwise ptr holds.
- Handshake:
  - A requester keeps req/op/a_in/b_in stable until it samples its gnt bit high.
  - It may reassert req the next cycle for a new op.
  - gnt depends only on req, hold and ptr; no combinational path from op or operands.
- Pipeline:
  - At accept edge k, stage 0 registers op, a, b and tag.
  - The operation is computed combinationally from stage 0 and registered at edge k+1.
  - LATENCY-1 further delay stages follow.
  - res_valid is high for exactly the cycle after edge k+LATENCY.
  - Throughput is 1 op/cycle; results return in accept order.
- busy = OR of all stage valids.
- Opcodes, all unsigned, results truncated to DATAWIDTH:
  - 000 ADD: a+b mod 2^W.
  - 001 SUB: a-b mod 2^W.
  - 010 MUL: low W bits of a*b.
  - 011 DIV: a/b; b=0 gives all ones.
  - 100 MOD: a%b; b=0 gives a.
  - 101 SHL: a << b[$clog2(W)-1:0].
  - 110 SHR: logical a >> b[$clog2(W)-1:0].
  - 111 COMP: res=0; cmp carries the flags.
- Exactly one cmp bit is set whenever res_valid=1.
- Simultaneous events:
  - hold asserted in the same cycle as req: no grant.
  - Reset released mid-cycle: first grant evaluated from ptr=0.
  - Result outputs hold their last value when res_valid=0.

Test Plan:
1. After reset, LATENCY=2, req=0100, op2=ADD, a=1, b=2 -> gnt=0100 that cycle; res_valid high 2 edges later with res=3, res_tag=2, cmp=010; busy high during flight.
2. req=1111 held continuously from reset -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; res_tag sequence 0, 1, 2, 3, 0, one per cycle.
3. W=8 back-to-back ops from requester 1 -> DIV 6/3=2, MOD 7%3=1, MUL 4*2=8, MUL 16*16=0x00, SUB 5-4=1, SUB 0-1=0xFF, SHL 1<<1=2, SHR 8>>2=2, DIV 9/0=0xFF, MOD 9%0=9; all in order, one per cycle.
4. COMP with a=2, b=3 -> res=0, cmp=010; a=3, b=3 -> cmp=001; a=4, b=3 -> cmp=100.
5. Two ops in flight, then hold=1 with req=0011 -> gnt=0000 while both results still emerge; hold=0 -> grant resumes at ptr.
6. Assert rst low one cycle after an accept -> no res_valid for that op; after release res=0 and busy=0, and req=1000 with req=0001 together grants requester 0 first.
